// File: rtl/reg_writeback_if.sv
// Register-file write-side bus: ALU results, load issue/return, and the
// reg_file write port with its scoreboard/status outputs.
interface reg_writeback_if #(
  parameter int unsigned W      = 8,
  parameter int unsigned D      = 4,
  parameter int unsigned QDEPTH = 4
);
  localparam int unsigned NumRegs = 2 ** D;
  localparam int unsigned CntW    = $clog2(QDEPTH) + 1;

  logic                alu_valid;
  logic                alu_ready;
  logic [D-1:0]        alu_waddr;
  logic [W-1:0]        alu_data;
  logic                ld_issue;
  logic                ld_ready;
  logic [D-1:0]        ld_waddr;
  logic                mem_rvalid;
  logic [W-1:0]        mem_rdata;
  logic                write_en;
  logic [D-1:0]        waddr;
  logic [W-1:0]        data_in;
  logic [NumRegs-1:0]  pend_mask;
  logic [CntW-1:0]     q_count;
  logic                err_spurious;

  // Producer side: execute/memory stages (and the bench).
  modport master (
    output alu_valid, alu_waddr, alu_data, ld_issue, ld_waddr, mem_rvalid, mem_rdata,
    input  alu_ready, ld_ready, write_en, waddr, data_in, pend_mask, q_count, err_spurious
  );

  // Sequencer side.
  modport slave (
    input  alu_valid, alu_waddr, alu_data, ld_issue, ld_waddr, mem_rvalid, mem_rdata,
    output alu_ready, ld_ready, write_en, waddr, data_in, pend_mask, q_count, err_spurious
  );
endinterface

// File: rtl/reg_writeback.sv
// Write-side sequencer for the register file. Merges ALU results and load
// returns into an in-order queue, commits one write per cycle, and exposes a
// pending-write scoreboard for decode-stage stalls.
module reg_writeback #(
  parameter int unsigned W      = 8,
  parameter int unsigned D      = 4,
  parameter int unsigned QDEPTH = 4
) (
  input logic           CLK,
  input logic           Reset,
  reg_writeback_if.slave bus
);
  localparam int unsigned PtrW    = $clog2(QDEPTH);
  localparam int unsigned CntW    = PtrW + 1;
  localparam int unsigned NumRegs = 2 ** D;

  typedef struct packed {
    logic [D-1:0] addr;
    logic [W-1:0] data;
  } entry_t;

  entry_t            q_mem_q [QDEPTH];
  entry_t            q_mem_d [QDEPTH];
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              ld_out_q, ld_out_d;
  logic [D-1:0]      ld_tag_q, ld_tag_d;
  // Set by reset: a load issued before reset may still return; its data is
  // dropped silently. Cleared by that return or by the next accepted issue.
  logic              orphan_q, orphan_d;
  logic              err_q, err_d;
  logic              we_q, we_d;
  entry_t            out_q, out_d;

  logic              ld_ret, ld_acc, alu_rdy, alu_acc, spurious;
  logic              pop, push_a_v, push_b_v;
  logic [1:0]        n_in, n_push;
  entry_t            ld_entry, alu_entry, in0, in1, push_a, push_b;
  logic [NumRegs-1:0] pend;

  // Queue/output-stage next state: pop head or bypass newest-oldest arrival.
  always_comb begin
    ld_ret    = bus.mem_rvalid & ld_out_q;
    spurious  = bus.mem_rvalid & ~ld_out_q;
    ld_acc    = bus.ld_issue & ~ld_out_q;
    // One slot stays free so a load return can always be absorbed.
    alu_rdy   = (cnt_q <= CntW'(QDEPTH - 2));
    alu_acc   = bus.alu_valid & alu_rdy;
    ld_entry  = '{addr: ld_tag_q, data: bus.mem_rdata};
    alu_entry = '{addr: bus.alu_waddr, data: bus.alu_data};
    // Load return is older than a same-cycle ALU result.
    in0       = ld_ret ? ld_entry : alu_entry;
    in1       = alu_entry;
    n_in      = {1'b0, ld_ret} + {1'b0, alu_acc};

    pop      = 1'b0;
    push_a_v = 1'b0;
    push_b_v = 1'b0;
    push_a   = in0;
    push_b   = in1;
    we_d     = 1'b0;
    out_d    = out_q;

    if (cnt_q != '0) begin
      pop      = 1'b1;
      we_d     = 1'b1;
      out_d    = q_mem_q[rd_ptr_q];
      push_a_v = (n_in != 2'd0);
      push_b_v = (n_in == 2'd2);
    end else if (n_in != 2'd0) begin
      we_d     = 1'b1;
      out_d    = in0;
      push_a_v = (n_in == 2'd2);
      push_a   = in1;
    end

    n_push = {1'b0, push_a_v} + {1'b0, push_b_v};

    q_mem_d = q_mem_q;
    if (push_a_v) q_mem_d[wr_ptr_q] = push_a;
    if (push_b_v) q_mem_d[wr_ptr_q + PtrW'(1)] = push_b;

    wr_ptr_d = wr_ptr_q + PtrW'(n_push);
    rd_ptr_d = rd_ptr_q + PtrW'(pop);
    cnt_d    = cnt_q + CntW'(n_push) - CntW'(pop);
  end

  // Load tag tracking and the sticky spurious-return flag.
  always_comb begin
    ld_out_d = ld_out_q;
    ld_tag_d = ld_tag_q;
    orphan_d = orphan_q;
    err_d    = err_q;
    if (ld_ret) begin
      ld_out_d = 1'b0;
    end else if (ld_acc) begin
      ld_out_d = 1'b1;
      ld_tag_d = bus.ld_waddr;
      orphan_d = 1'b0;
    end
    if (spurious) begin
      orphan_d = 1'b0;
      if (!orphan_q) err_d = 1'b1;
    end
  end

  // Scoreboard: queued entries, the committing output stage, the load tag.
  always_comb begin
    pend = '0;
    for (int i = 0; i < QDEPTH; i++) begin
      if (CntW'(i) < cnt_q) pend[q_mem_q[rd_ptr_q + PtrW'(i)].addr] = 1'b1;
    end
    if (we_q)     pend[out_q.addr] = 1'b1;
    if (ld_out_q) pend[ld_tag_q]   = 1'b1;
  end

  // State registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      q_mem_q  <= '{default: '0};
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
      ld_out_q <= 1'b0;
      ld_tag_q <= '0;
      orphan_q <= 1'b1;
      err_q    <= 1'b0;
      we_q     <= 1'b0;
      out_q    <= '0;
    end else begin
      q_mem_q  <= q_mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
      ld_out_q <= ld_out_d;
      ld_tag_q <= ld_tag_d;
      orphan_q <= orphan_d;
      err_q    <= err_d;
      we_q     <= we_d;
      out_q    <= out_d;
    end
  end

  assign bus.alu_ready    = alu_rdy;
  assign bus.ld_ready     = ~ld_out_q;
  assign bus.write_en     = we_q;
  assign bus.waddr        = out_q.addr;
  assign bus.data_in      = out_q.data;
  assign bus.pend_mask    = pend;
  assign bus.q_count      = cnt_q;
  assign bus.err_spurious = err_q;

endmodule
